uart_tx_periph: RTL

- Memory-mapped UART transmitter on the data bus, downstream of the load/store unit.
- The LSU decodes dbus_address[31:28]==4'h8 and drives uart_sel, we, re, reg_address and input_data into this block.
- The block provides a 4-entry TX byte FIFO, a programmable baud divider and a status register, and serialises bytes as 8N1 frames on the tx pin.
- Read data is combinational, so single-cycle loads complete in the same cycle.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_periph_fifo.sv | 39 +++
 rtl/uart_tx_periph.sv | 108 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, register offsets and STATUS bit positions for the UART transmitter.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_BAUD   = 2'd2;
    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_IRQ   = 4;
endpackage

// File: rtl/uart_tx_periph_fifo.sv
// sync_fifo: single-clock FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped 8N1 UART transmitter with TX FIFO, baud divider and status register.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int          width      = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RST   = 16'd868
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             uart_sel,
    input  logic             we,
    input  logic             re,
    input  logic [width-1:0] reg_address,
    input  logic [width-1:0] input_data,
    output logic [width-1:0] rdata,
    output logic             tx,
    output logic             tx_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    uart_state_e state, state_n;
    logic [7:0]    shift, fifo_dout;
    logic [2:0]    bit_cnt;
    logic [15:0]   baud_div, baud_cnt, reload;
    logic [1:0]    off;
    logic [CW-1:0] count;
    logic          wr, push, pop, full, empty, tick, overflow, unused;
    assign off    = reg_address[3:2];
    assign wr     = uart_sel & we;
    assign push   = wr && off == UART_TXDATA;
    assign reload = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
    assign tick   = baud_cnt == 16'd0;
    assign tx     = (state == START) ? 1'b0 : (state == DATA) ? shift[0] : 1'b1;
    assign tx_irq = empty && state == IDLE;
    assign unused = ^{reg_address[width-1:4], reg_address[1:0], input_data[width-1:16], count};
    sync_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (input_data[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                pop     = !empty;
                state_n = empty ? IDLE : START;
            end
            START: state_n = tick ? DATA : START;
            DATA:  state_n = (tick && bit_cnt == 3'd7) ? STOP : DATA;
            STOP: begin
                pop     = tick && !empty;
                state_n = !tick ? STOP : empty ? IDLE : START;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    // The divisor is sampled only at reload, so a BAUD write never truncates the bit in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            baud_div <= BAUD_RST;
            overflow <= 1'b0;
        end else begin
            if (wr && off == UART_BAUD) baud_div <= input_data[15:0];
            if (push && full) overflow <= 1'b1;
            else if (wr && off == UART_STATUS) overflow <= 1'b0;
            if (pop) begin
                shift    <= fifo_dout;
                baud_cnt <= reload;
            end else if (state != IDLE) begin
                baud_cnt <= tick ? reload : baud_cnt - 16'd1;
                if (tick && state == DATA) begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end
    always_comb begin
        rdata = '0;
        if (uart_sel && re) begin
            case (off)
                UART_STATUS: begin
                    rdata[ST_BUSY]  = state != IDLE;
                    rdata[ST_FULL]  = full;
                    rdata[ST_EMPTY] = empty;
                    rdata[ST_OVF]   = overflow;
                    rdata[ST_IRQ]   = tx_irq;
                end
                UART_BAUD: rdata[15:0] = baud_div;
                default:   rdata = '0;
            endcase
        end
    end
endmodule
